// File: rtl/gpio_wb_arbiter.sv
// rtl/gpio_wb_arbiter.sv - two-master round-robin Wishbone arbiter in front of a GPIO slave
// Optional ack watchdog: define GPIO_ARB_TIMEOUT_EN to enable the BUSY timeout and mN_err_o.
module gpio_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("gpio_wb_arbiter: TIMEOUT_CYC must be in 2..255");
  end

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   req0, req1;
  logic   timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;

  // Counter holds 0 in IDLE, so it is clear on every BUSY entry.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (!s_ack_i) begin
      timeout = (cnt_q == TO_LAST);
      cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_adr_o      = 32'd0;
    s_sel_o      = 4'd0;
    s_dat_o      = 32'd0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m1_err_o     = 1'b0;
    grant_o      = 2'b00;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          if (last_grant_q) begin
            state_d      = BUSY0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = BUSY1;
            last_grant_d = 1'b1;
          end
        end else if (req0) begin
          state_d      = BUSY0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = BUSY1;
          last_grant_d = 1'b1;
        end
      end

      // A dropped cyc means abort: any ack arriving that cycle is swallowed.
      BUSY0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i & ~timeout;
        s_stb_o  = m0_stb_i & ~timeout;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i & m0_cyc_i;
        m0_err_o = timeout & m0_cyc_i;
        if (!m0_cyc_i || s_ack_i || timeout) begin
          state_d = IDLE;
        end
      end

      BUSY1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i & ~timeout;
        s_stb_o  = m1_stb_i & ~timeout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i & m1_cyc_i;
        m1_err_o = timeout & m1_cyc_i;
        if (!m1_cyc_i || s_ack_i || timeout) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// tb/tb_gpio_wb_arbiter.sv - scoreboard bench for gpio_wb_arbiter (honours GPIO_ARB_TIMEOUT_EN)
module tb_gpio_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] slave_rdata = 32'd0;
  logic        slave_ack = 1'b0;
  logic        slave_mute = 1'b0;
  logic [1:0]  grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  gpio_wb_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(slave_rdata), .s_ack_i(slave_ack),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // One-cycle registered-ack slave.
  always @(posedge clk) begin
    if (rst_i) slave_ack <= 1'b0;
    else       slave_ack <= s_cyc_o & s_stb_o & ~slave_ack & ~slave_mute;
  end

  // Monitor: every ack/err the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o)) begin
      n_tests++;
      if ((m0_ack_o || m0_err_o) && (m1_ack_o || m1_err_o)) begin
        n_fail++;
        $display("FAIL both_masters_responded ack=%b%b err=%b%b required one owner",
                 m1_ack_o, m0_ack_o, m1_err_o, m0_err_o);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_response ack=%b%b err=%b%b required none",
                 m1_ack_o, m0_ack_o, m1_err_o, m0_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ((m1_ack_o || m1_err_o) != (mon_e.m == 1) ||
            (m0_err_o || m1_err_o) != mon_e.err ||
            (!mon_e.err && ((mon_e.m == 1) ? m1_dat_o : m0_dat_o) != mon_e.dat)) begin
          n_fail++;
          $display("FAIL response got ack=%b%b err=%b%b dat=%h required m%0d err=%0d dat=%h",
                   m1_ack_o, m0_ack_o, m1_err_o, m0_err_o,
                   (m1_ack_o ? m1_dat_o : m0_dat_o), mon_e.m, mon_e.err, mon_e.dat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic to_drv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int m, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
    else        begin m1_cyc_i = 0; m1_stb_i = 0; end
  endtask

  task automatic wait_done(input int m);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((m == 0) ? (m0_ack_o || m0_err_o) : (m1_ack_o || m1_err_o)) begin
        to_drv();
        drop(m);
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL m%0d_response_timeout got none required ack within 60 cycles", m);
    to_drv();
    drop(m);
  endtask

  task automatic master_xfer(input int m, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
    drive_req(m, we, adr, dat, sel);
    wait_done(m);
  endtask

  task automatic tie_trace(input string tag);
    logic [1:0] tr [7];
    tr = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("%s_grant_c%0d", tag, i), {30'd0, grant_o}, {30'd0, tr[i]});
    end
  endtask

  task automatic both_tie(input string tag);
    exp_q.push_back('{m: 0, err: 1'b0, dat: slave_rdata});
    exp_q.push_back('{m: 1, err: 1'b0, dat: slave_rdata});
    fork
      master_xfer(0, 1'b1, 32'h20, 32'h1111_0000, 4'hF);
      master_xfer(1, 1'b1, 32'h24, 32'h2222_0000, 4'h3);
      tie_trace(tag);
    join
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish required finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    chk("rst_ack_err", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
    to_drv();
    rst_i = 0;

    // Single m0 write with a one-cycle slave.
    to_drv();
    exp_q.push_back('{m: 0, err: 1'b0, dat: 32'd0});
    drive_req(0, 1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk);
    chk("wr_c0_grant", {30'd0, grant_o}, 32'd0);
    chk("wr_c0_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    to_drv();
    @(negedge clk);
    chk("wr_c1_grant", {30'd0, grant_o}, 32'd1);
    chk("wr_c1_s_adr", s_adr_o, 32'h4);
    chk("wr_c1_s_dat", s_dat_o, 32'hA5A5_A5A5);
    chk("wr_c1_s_sel_we", {27'd0, s_sel_o, s_we_o}, {27'd0, 4'hF, 1'b1});
    chk("wr_c1_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd3);
    wait_done(0);
    @(negedge clk);
    chk("wr_c3_grant", {30'd0, grant_o}, 32'd0);

    // Reset leaves last_grant=1, but m0 was just served: reset again for the tie test.
    to_drv();
    rst_i = 1;
    to_drv();
    rst_i = 0;
    to_drv();
    slave_rdata = 32'h0000_1234;
    both_tie("tie1");
    to_drv();
    both_tie("tie2");

    // m1 read, broadcast data.
    to_drv();
    slave_rdata = 32'h0000_00FF;
    exp_q.push_back('{m: 1, err: 1'b0, dat: 32'h0000_00FF});
    master_xfer(1, 1'b0, 32'h8, 32'd0, 4'hF);

    // m0 aborts in the cycle its ack arrives; pending m1 follows.
    to_drv();
    exp_q.push_back('{m: 1, err: 1'b0, dat: 32'h0000_00FF});
    drive_req(0, 1'b1, 32'h10, 32'h55, 4'hF);
    to_drv();
    drive_req(1, 1'b1, 32'h14, 32'h66, 4'h1);
    @(negedge clk);
    chk("abort_c1_grant", {30'd0, grant_o}, 32'd1);
    to_drv();
    drop(0);
    @(negedge clk);
    chk("abort_c2_m0_ack_err", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
    chk("abort_c2_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    to_drv();
    @(negedge clk);
    chk("abort_c3_grant", {30'd0, grant_o}, 32'd0);
    to_drv();
    @(negedge clk);
    chk("abort_c4_grant", {30'd0, grant_o}, 32'd2);
    wait_done(1);

    // Slave never acks.
    to_drv();
    slave_mute = 1;
`ifdef GPIO_ARB_TIMEOUT_EN
    exp_q.push_back('{m: 0, err: 1'b1, dat: 32'd0});
`endif
    drive_req(0, 1'b0, 32'h30, 32'd0, 4'hF);
    for (int k = 1; k <= 16; k++) begin
      to_drv();
    end
    @(negedge clk);
`ifdef GPIO_ARB_TIMEOUT_EN
    chk("to_c16_m0_err", {31'd0, m0_err_o}, 32'd1);
    chk("to_c16_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    to_drv();
    drop(0);
    @(negedge clk);
    chk("to_c17_grant", {30'd0, grant_o}, 32'd0);
    chk("to_c17_m0_err", {31'd0, m0_err_o}, 32'd0);
`else
    chk("to_c16_grant", {30'd0, grant_o}, 32'd1);
    chk("to_c16_m0_err", {31'd0, m0_err_o}, 32'd0);
    for (int k = 17; k <= 40; k++) begin
      to_drv();
    end
    @(negedge clk);
    chk("to_c40_grant", {30'd0, grant_o}, 32'd1);
    to_drv();
    drop(0);
    to_drv();
    @(negedge clk);
    chk("to_after_abort_grant", {30'd0, grant_o}, 32'd0);
`endif

    // Reset during BUSY1 abandons the transfer.
    to_drv();
    drive_req(1, 1'b1, 32'h40, 32'h77, 4'hF);
    to_drv();
    @(negedge clk);
    chk("rstb_c1_grant", {30'd0, grant_o}, 32'd2);
    to_drv();
    rst_i = 1;
    drop(1);
    to_drv();
    rst_i = 0;
    @(negedge clk);
    chk("rstb_grant", {30'd0, grant_o}, 32'd0);
    chk("rstb_ack_err", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
    chk("rstb_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    slave_mute = 0;
    to_drv();
    both_tie("tie3");

    to_drv();
    to_drv();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_wb_arbiter.md
GPIO_WB_ARBITER -- requirements
Module: gpio_wb_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 16, giving the maximum BUSY cycles allowed without slave ack (valid range 2..255).
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have ports mN_cyc_i/mN_stb_i/mN_we_i (N=0,1), input, 1 bit each: the Wishbone cycle, strobe and write signals of master N.
REQ-005 The module SHALL have ports mN_adr_i, input, 32 bits, and mN_dat_i, input, 32 bits: master N address and write data.
REQ-006 The module SHALL have port mN_sel_i, input, 4 bits: master N byte selects.
REQ-007 The module SHALL have ports mN_dat_o, output, 32 bits, and mN_ack_o/mN_err_o, output, 1 bit each: master N read data, ack and error.
REQ-008 The module SHALL have ports s_cyc_o/s_stb_o/s_we_o, output, 1 bit; s_adr_o, output, 32 bits; s_sel_o, output, 4 bits; s_dat_o, output, 32 bits: the slave-side request to the GPIO block.
REQ-009 The module SHALL have ports s_dat_i, input, 32 bits, and s_ack_i, input, 1 bit: the slave read data and ack.
REQ-010 The module SHALL have port grant_o, output, 2 bits: the one-hot current owner (bit N = master N), 00 when idle.

Function
REQ-011 A request from master N SHALL be defined as mN_cyc_i & mN_stb_i.
REQ-012 FSM states SHALL be IDLE, BUSY0 and BUSY1; the slave bus SHALL be inactive (s_cyc_o = s_stb_o = 0) in IDLE.
REQ-013 In IDLE with exactly one request, the FSM SHALL go to BUSY of that master on the next edge.
REQ-014 In IDLE with both requesting, the FSM SHALL grant the master other than last_grant (round-robin), and last_grant SHALL update to the granted master on each grant.
REQ-015 In BUSYn, s_adr_o/s_dat_o/s_sel_o/s_we_o SHALL mux combinationally from master n, and s_cyc_o/s_stb_o SHALL equal mn_cyc_i/mn_stb_i.
REQ-016 mN_ack_o SHALL equal s_ack_i while in BUSYN, and SHALL be 0 otherwise; the non-owner never sees ack or err.
REQ-017 mN_dat_o SHALL be s_dat_i for both masters (broadcast), qualified by ack only.
REQ-018 On s_ack_i in BUSYn, the FSM SHALL return to IDLE on the next edge; the mandatory IDLE cycle clears the slave's registered ack before any new grant.
REQ-019 Latency SHALL be: request seen at cycle 0 -> slave driven at cycle 1 -> ack at cycle 2 with a 1-cycle slave -> IDLE at cycle 3.
REQ-020 If the owner drops mn_cyc_i before ack (abort), the FSM SHALL return to IDLE on the next edge with no ack or err, and any slave ack in that cycle SHALL be discarded.
REQ-021 A new request from the owner in the IDLE cycle after its own transfer SHALL follow REQ-013/014, so the other master wins if it is also requesting.

Reset
REQ-022 While rst_i=1 at an edge, the state SHALL be IDLE, last_grant=1 (master 0 wins the first tie), the timeout counter SHALL be 0, and all outputs except mN_dat_o SHALL be 0; this SHALL apply mid-transfer too, abandoning the transfer without ack.

Configuration
REQ-023 Macro GPIO_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without s_ack_i.
REQ-024 With GPIO_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC, the module SHALL pulse the owner's mN_err_o for one cycle, force s_cyc_o/s_stb_o to 0 that cycle, and go to IDLE.
REQ-025 Macro GPIO_ARB_TIMEOUT_EN undefined: there SHALL be no counter, mN_err_o SHALL be tied to 0, and BUSY SHALL wait indefinitely for ack or abort.

Verification
REQ-026 The bench SHALL check: m0 write adr 0x4, dat 0xA5A5A5A5, sel 0xF, slave acks after 1 cycle -> s_* mirror m0 at cycle 1, m0_ack_o at cycle 2, grant_o 01 then 00.
REQ-027 The bench SHALL check: both masters request from reset -> m0 served first, then IDLE one cycle, then m1; repeating both -> m0 next.
REQ-028 The bench SHALL check: m1 read, slave returns s_dat_i=0x0000_00FF -> m1_dat_o=0xFF with m1_ack_o, and m0_ack_o stays 0 throughout.
REQ-029 The bench SHALL check: m0 drops cyc in BUSY0 before ack -> IDLE next cycle, no ack or err, and a pending m1 is granted after.
REQ-030 The bench SHALL check, with GPIO_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: the slave never acks -> m0_err_o pulses once at BUSY cycle 16 and the FSM returns to IDLE; without the macro, the FSM stays in BUSY0.
REQ-031 The bench SHALL check: rst_i asserted during BUSY1 -> next edge grant_o=00, all acks 0, and the next tie goes to m0.
